vram_snoop_writer: RTL and testbench

Write-side companion of the video controller's VRAM read port. Snoops Z80 memory-write cycles and, optionally, loader writes. Filters those that hit the screen banks (RAM 5 and RAM 7) and queues them in a small FIFO. Drains the FIFO into the 32 KB dual-port VRAM write port through a request/grant handshake, so the video fetch side always sees a coherent copy of screen memory.

---
 rtl/vram_pkg.sv | 28 ++
 rtl/vram_wfifo.sv | 58 +++++
 rtl/vram_snoop_writer.sv | 119 +++++++++++
 tb/tb_vram_snoop_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM snoop writer: queued entry layout,
// screen bank numbers and VRAM write-port address width.
package vram_pkg;

    localparam int VRAM_AW = 15;

    localparam logic [2:0] BANK_SCR0 = 3'd5;
    localparam logic [2:0] BANK_SCR1 = 3'd7;

    typedef struct packed {
        logic        bank7;
        logic [13:0] offset;
        logic [7:0]  data;
    } vram_entry_t;

    localparam int ENTRY_W = $bits(vram_entry_t);

    function automatic vram_entry_t make_entry(input logic bank7,
                                               input logic [13:0] offset,
                                               input logic [7:0] data);
        vram_entry_t e;
        e.bank7  = bank7;
        e.offset = offset;
        e.data   = data;
        return e;
    endfunction

endpackage

// File: rtl/vram_wfifo.sv
// Generic synchronous FIFO, depth 2**FIFO_AW, first-word-fall-through read.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module vram_wfifo #(
    parameter int WIDTH   = 23,
    parameter int FIFO_AW = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_count
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

    logic [WIDTH-1:0]   r_mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // validity, and a reset-free array maps onto plain RAM/LUT cells.
    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/vram_snoop_writer.sv
// Snoops CPU (and optionally loader) writes to screen banks 5/7 and drains them
// into the VRAM write port. Loader path enabled by defining VRAM_SNOOP_LOADER_EN.
module vram_snoop_writer
    import vram_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [15:0]        addr,
    input  logic [7:0]         din,
    input  logic               nMREQ,
    input  logic               nWR,
    input  logic               nRFSH,
    input  logic               m128,
    input  logic [2:0]         page_ram,
    input  logic               ldr_wr,
    input  logic [2:0]         ldr_bank,
    input  logic [13:0]        ldr_addr,
    input  logic [7:0]         ldr_data,
    output logic               ldr_busy,
    output logic               vram_wreq,
    input  logic               vram_wgnt,
    output logic [VRAM_AW-1:0] vram_waddr,
    output logic [7:0]         vram_wdata,
    output logic               overflow
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

    logic        r_strobe;
    logic        r_strobe_d;
    logic        r_armed;
    logic        r_overflow;
    logic        w_cpu_wr;
    logic        w_capture;
    logic        w_scr5;
    logic        w_scr7;
    logic        w_cpu_hit;
    logic        w_ldr_hit;
    logic        w_can_push;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [FIFO_AW:0] w_count;
    vram_entry_t w_cpu_entry;
    vram_entry_t w_ldr_entry;
    vram_entry_t w_push_entry;
    vram_entry_t w_head;

    assign w_cpu_wr = ~nMREQ & ~nWR & nRFSH;

    // r_armed blocks a capture for a write cycle already under way at reset
    // release; it arms once the raw strobe has been seen inactive.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_strobe   <= 1'b0;
            r_strobe_d <= 1'b0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_strobe   <= w_cpu_wr;
            r_strobe_d <= r_strobe;
            if (!w_cpu_wr) r_armed <= 1'b1;
            if (w_cpu_hit && !w_can_push) r_overflow <= 1'b1;
        end
    end

    assign w_capture = r_strobe & ~r_strobe_d & r_armed;

    assign w_scr5 = (addr[15:14] == 2'b01) |
                    ((addr[15:14] == 2'b11) & m128 & (page_ram == BANK_SCR0));
    assign w_scr7 = (addr[15:14] == 2'b11) & m128 & (page_ram == BANK_SCR1);

    assign w_cpu_hit   = w_capture & (w_scr5 | w_scr7);
    assign w_cpu_entry = make_entry(w_scr7, addr[13:0], din);

`ifdef VRAM_SNOOP_LOADER_EN
    assign w_ldr_hit   = ldr_wr & ~w_capture &
                         ((ldr_bank == BANK_SCR0) | (ldr_bank == BANK_SCR1));
    assign w_ldr_entry = make_entry(ldr_bank == BANK_SCR1, ldr_addr, ldr_data);
    assign ldr_busy    = w_full | w_capture;
`else
    logic w_ldr_unused;
    // Loader ports stay on the interface but have no effect in this build.
    assign w_ldr_unused = ^{ldr_wr, ldr_bank, ldr_addr, ldr_data};
    assign w_ldr_hit    = 1'b0;
    assign w_ldr_entry  = '0;
    assign ldr_busy     = w_ldr_unused & 1'b0;
`endif

    assign w_pop        = ~w_empty & vram_wgnt;
    assign w_can_push   = (w_count < DEPTH) | w_pop;
    assign w_push       = (w_cpu_hit | w_ldr_hit) & w_can_push;
    assign w_push_entry = w_cpu_hit ? w_cpu_entry : w_ldr_entry;

    vram_wfifo #(
        .WIDTH   (ENTRY_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Unwritten storage may be undefined, so the head is masked while empty.
    assign vram_wreq  = ~w_empty;
    assign vram_waddr = w_empty ? '0 : {w_head.bank7, w_head.offset};
    assign vram_wdata = w_empty ? '0 : w_head.data;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_vram_snoop_writer.sv
// Directed self-checking bench for vram_snoop_writer; granted writes are
// recorded on the falling edge and compared against hand-computed entries.
module tb_vram_snoop_writer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        nMREQ, nWR, nRFSH, m128;
    logic [2:0]  page_ram;
    logic        ldr_wr;
    logic [2:0]  ldr_bank;
    logic [13:0] ldr_addr;
    logic [7:0]  ldr_data;
    logic        ldr_busy, vram_wreq, vram_wgnt, overflow;
    logic [14:0] vram_waddr;
    logic [7:0]  vram_wdata;

    int n_cmp = 0;
    int n_mis = 0;
    logic [22:0] seen [$];

    always #5 clk_sys = ~clk_sys;

    vram_snoop_writer #(.FIFO_AW(2)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .addr       (addr),
        .din        (din),
        .nMREQ      (nMREQ),
        .nWR        (nWR),
        .nRFSH      (nRFSH),
        .m128       (m128),
        .page_ram   (page_ram),
        .ldr_wr     (ldr_wr),
        .ldr_bank   (ldr_bank),
        .ldr_addr   (ldr_addr),
        .ldr_data   (ldr_data),
        .ldr_busy   (ldr_busy),
        .vram_wreq  (vram_wreq),
        .vram_wgnt  (vram_wgnt),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .overflow   (overflow)
    );

    always @(negedge clk_sys) begin
        if (vram_wreq && vram_wgnt) seen.push_back({vram_waddr, vram_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic next_seen(output logic [31:0] e);
        if (seen.size() > 0) e = {9'd0, seen.pop_front()};
        else e = 32'hDEAD_0000;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
        step(3);
        nMREQ = 1'b1; nWR = 1'b1;
        step(2);
    endtask

    logic [31:0] e;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; din = '0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
        m128 = 1'b0; page_ram = 3'd0; ldr_wr = 1'b0; ldr_bank = 3'd0;
        ldr_addr = '0; ldr_data = '0; vram_wgnt = 1'b1;
        step(3);
        chk("reset_wreq", vram_wreq, 0);
        chk("reset_waddr", vram_waddr, 0);
        chk("reset_wdata", vram_wdata, 0);
        chk("reset_busy", ldr_busy, 0);
        chk("reset_ovf", overflow, 0);
        reset = 1'b0;
        step(2);

        // Latency: strobe rises in cycle N, request visible in cycle N+2.
        addr = 16'h4000; din = 8'hA5; nMREQ = 1'b0; nWR = 1'b0;
        step(1);
        chk("lat_n1_wreq", vram_wreq, 0);
        step(1);
        chk("lat_n2_wreq", vram_wreq, 1);
        chk("lat_waddr", vram_waddr, 15'h0000);
        chk("lat_wdata", vram_wdata, 8'hA5);
        step(1);
        chk("lat_single_pulse", vram_wreq, 0);
        nMREQ = 1'b1; nWR = 1'b1;
        step(2);
        chk("lat_count", seen.size(), 1);
        seen.delete();

        m128 = 1'b1; page_ram = 3'd7;
        cpu_write(16'hDAFF, 8'h3C);
        chk("bank7_count", seen.size(), 1);
        next_seen(e);
        chk("bank7_entry", e, {9'd0, 15'h5AFF, 8'h3C});
        page_ram = 3'd3;
        cpu_write(16'hDAFF, 8'h3C);
        chk("page3_ignored", seen.size(), 0);
        page_ram = 3'd5;
        cpu_write(16'hC001, 8'h5A);
        next_seen(e);
        chk("page5_entry", e, {9'd0, 15'h0001, 8'h5A});
        m128 = 1'b0;
        cpu_write(16'hC001, 8'h5A);
        chk("m128_off_ignored", seen.size(), 0);
        cpu_write(16'h8000, 8'h77);
        chk("addr8000_ignored", seen.size(), 0);

        nRFSH = 1'b0;
        cpu_write(16'h4000, 8'h66);
        nRFSH = 1'b1;
        chk("refresh_ignored", seen.size(), 0);

        addr = 16'h4123; din = 8'h11; nMREQ = 1'b0; nWR = 1'b0;
        step(10);
        nMREQ = 1'b1; nWR = 1'b1;
        step(3);
        chk("long_strobe_count", seen.size(), 1);
        next_seen(e);
        chk("long_strobe_entry", e, {9'd0, 15'h0123, 8'h11});

        // Overflow: four fit, fifth is dropped and flagged.
        vram_wgnt = 1'b0;
        for (int i = 1; i <= 4; i++) cpu_write(16'h4000 + 16'(i), 8'(i));
        chk("ovf_after4", overflow, 0);
        chk("ovf_busy_full", ldr_busy, `ifdef VRAM_SNOOP_LOADER_EN 1 `else 0 `endif);
        cpu_write(16'h4005, 8'h05);
        chk("ovf_after5", overflow, 1);
        chk("ovf_head_addr", vram_waddr, 15'h0001);
        chk("ovf_head_data", vram_wdata, 8'h01);
        vram_wgnt = 1'b1;
        step(3);
        chk("drain_3_wreq", vram_wreq, 1);
        step(1);
        chk("drain_4_empty", vram_wreq, 0);
        chk("drain_count", seen.size(), 4);
        for (int i = 1; i <= 4; i++) begin
            next_seen(e);
            chk($sformatf("drain_order_%0d", i), e, {9'd0, 15'(i), 8'(i)});
        end
        chk("ovf_sticky", overflow, 1);

`ifdef VRAM_SNOOP_LOADER_EN
        // Loader latency with grant held off.
        vram_wgnt = 1'b0;
        ldr_wr = 1'b1; ldr_bank = 3'd7; ldr_addr = 14'h0020; ldr_data = 8'hC3;
        chk("ldr_lat_n", vram_wreq, 0);
        step(1);
        ldr_wr = 1'b0;
        chk("ldr_lat_n1", vram_wreq, 1);
        chk("ldr_lat_addr", vram_waddr, 15'h4020);
        ldr_wr = 1'b1; ldr_bank = 3'd3;
        step(1);
        ldr_wr = 1'b0;
        vram_wgnt = 1'b1;
        step(3);
        chk("ldr_bank3_ignored", seen.size(), 1);
        seen.delete();

        // Collision: CPU capture wins, loader retries next cycle.
        addr = 16'h4010; din = 8'h99; nMREQ = 1'b0; nWR = 1'b0;
        step(1);
        ldr_wr = 1'b1; ldr_bank = 3'd5; ldr_addr = 14'h1800; ldr_data = 8'h47;
        chk("coll_busy", ldr_busy, 1);
        step(1);
        chk("retry_not_busy", ldr_busy, 0);
        step(1);
        ldr_wr = 1'b0;
        nMREQ = 1'b1; nWR = 1'b1;
        step(3);
        chk("coll_count", seen.size(), 2);
        next_seen(e);
        chk("coll_first_cpu", e, {9'd0, 15'h0010, 8'h99});
        next_seen(e);
        chk("coll_second_ldr", e, {9'd0, 15'h1800, 8'h47});
`else
        ldr_wr = 1'b1; ldr_bank = 3'd5; ldr_addr = 14'h1800; ldr_data = 8'h47;
        chk("noldr_busy", ldr_busy, 0);
        step(1);
        ldr_wr = 1'b0;
        step(3);
        chk("noldr_ignored", seen.size(), 0);
`endif

        // Reset mid-operation with a CPU write in progress across release.
        vram_wgnt = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(16'h4100 + 16'(i), 8'h20 + 8'(i));
        chk("pre_reset_wreq", vram_wreq, 1);
        addr = 16'h4200; din = 8'h42; nMREQ = 1'b0; nWR = 1'b0;
        reset = 1'b1;
        step(1);
        chk("rst_wreq", vram_wreq, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_waddr", vram_waddr, 0);
        reset = 1'b0;
        vram_wgnt = 1'b1;
        step(5);
        chk("rst_held_strobe", seen.size(), 0);
        nMREQ = 1'b1; nWR = 1'b1;
        step(2);
        cpu_write(16'h7FFF, 8'hEE);
        chk("post_rst_count", seen.size(), 1);
        next_seen(e);
        chk("post_rst_entry", e, {9'd0, 15'h3FFF, 8'hEE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
